cp0_vec: RTL
============

CP0_VEC -- requirements
Module: cp0_vec

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (1..8).
REQ-002 SHALL have parameter VEC_STRIDE, default 32'h20, byte offset between interrupt vectors.
REQ-003 SHALL have port clk  input  1  main clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port oper  input  2  CP0 operation: NONE, MFC0, MTC0, ERET.
REQ-006 SHALL have ports addr_r input 5 / data_r output 32 / addr_w input 5 / data_w input 32, for the register read port and the register write port.
REQ-007 SHALL have port ir_en  input  1  pipeline can accept an interrupt this cycle.
REQ-008 SHALL have port ir_in  input  NUM_IRQ  raw external interrupt lines, rising-edge sensitive.
REQ-009 SHALL have port ret_addr  input  32  address saved to EPC when an interrupt is taken.
REQ-010 SHALL have port jump_en  output  1  registered one-cycle redirect pulse.
REQ-011 SHALL have port jump_addr  output  32  registered redirect target.

Function
REQ-012 SHALL implement STATUS, CAUSE, EPC and EHBR; all other addresses read 0 and ignore writes.
- STATUS: [0] IE, [1] EXL, [8+NUM_IRQ-1:8] IM.
- CAUSE: [8+NUM_IRQ-1:8] IP, [4:2] serviced irq id.
REQ-013 SHALL make data_r combinational from addr_r, showing current register state.
REQ-014 SHALL apply MTC0 writes at the clock edge.
- CAUSE IP bits: write-1-to-clear; CAUSE id bits are read-only.
- STATUS, EPC, EHBR: fully writable.
REQ-015 SHALL register each ir_in bit and set IP[i] on the cycle a rising edge of line i is detected (prev 0, current 1).
REQ-016 SHALL take an interrupt when ir_en & IE & ~EXL & |(IP & IM); the lowest-index pending unmasked line wins.
REQ-017 SHALL, on take and in the same edge:
- set EPC = ret_addr;
- set EXL = 1;
- clear the winner's IP bit;
- set CAUSE id = winner index;
- drive jump_en = 1 and jump_addr = EHBR (see REQ-024).
REQ-018 SHALL, on oper == ERET, clear EXL and drive jump_en = 1, jump_addr = EPC on the next edge.
REQ-019 SHALL hold jump_en high for exactly one cycle per event and hold jump_addr at its last value otherwise.
REQ-020 SHALL prioritise ERET over take in the same cycle; the take is re-evaluated next cycle.
REQ-021 SHALL resolve simultaneous events as follows:
- MTC0 plus take in the same cycle: the take decision uses pre-write state, and the take's EPC/EXL/IP updates override the write to the same fields.
- A new edge on a line whose IP bit is being cleared (take or W1C) in the same cycle: the set wins.
REQ-022 SHALL prevent re-entry: no take while EXL = 1, regardless of IE and pending lines.

Reset
REQ-023 SHALL, when rst is high at an edge:
- clear STATUS, CAUSE, EPC, EHBR, the edge-detect flops, jump_en and jump_addr to 0;
- discard any pending edges and suppress any take or ERET in that cycle.

Configuration
REQ-024 SHALL honour macro CP0_VECTOR_EN.
- Defined: jump_addr on take = EHBR + winner index * VEC_STRIDE.
- Undefined: jump_addr on take = EHBR for every line.

Structure
REQ-025 SHALL place the oper encodings and the register addresses (STATUS 12, CAUSE 13, EPC 14, EHBR 15) in the shared mips_define package.
REQ-026 SHALL implement the lowest-index-wins priority encoder as sub-module cp0_prio_enc, parametrised by NUM_IRQ, with outputs valid and index.

Verification
REQ-027 SHALL cover these scenarios:
- Single interrupt: EHBR = 0x100, STATUS = 0x0F01, ir_en = 1, rising edge on line 2, ret_addr = 0x40 -> next edge jump_en = 1, jump_addr = 0x140 (vectored) or 0x100, EPC = 0x40, EXL = 1, CAUSE id = 2, IP[2] = 0.
- Priority: edges on lines 3 and 1 in the same cycle, IM = all ones -> line 1 taken, IP[3] stays 1. After ERET -> jump_addr = EPC; the next take selects line 3.
- Masking and W1C: IM[0] = 0, edge on line 0 -> no take, IP[0] = 1. Then MTC0 CAUSE = 0x100 -> IP[0] = 0. Then setting IM[0] -> still no take.
- Re-entry: during EXL = 1, edge on line 0 -> IP[0] set, no jump_en. After ERET -> take one cycle later.
- Reset mid-operation: rst asserted on the take cycle -> jump_en = 0, EPC = 0, all registers read 0 next cycle.

Source files
------------

// File: rtl/mips_define.sv
// Shared MIPS definitions: CP0 operation encodings and CP0 register addresses.
package mips_define;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned IRQ_IDX_W = 3;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MFC0 = 2'd1,
    OP_MTC0 = 2'd2,
    OP_ERET = 2'd3
  } cp0_op_e;

  localparam logic [REG_AW-1:0] CP0_STATUS = 5'd12;
  localparam logic [REG_AW-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [REG_AW-1:0] CP0_EPC    = 5'd14;
  localparam logic [REG_AW-1:0] CP0_EHBR   = 5'd15;

endpackage

// File: rtl/cp0_vec_if.sv
// Pipeline-facing bundle of the CP0 block: register ports, interrupt lines, redirect.
interface cp0_vec_if
  import mips_define::*;
#(
  parameter int unsigned NUM_IRQ = 4
);
  cp0_op_e               oper;
  logic [REG_AW-1:0]     addr_r;
  logic [XLEN-1:0]       data_r;
  logic [REG_AW-1:0]     addr_w;
  logic [XLEN-1:0]       data_w;
  logic                  ir_en;
  logic [NUM_IRQ-1:0]    ir_in;
  logic [XLEN-1:0]       ret_addr;
  logic                  jump_en;
  logic [XLEN-1:0]       jump_addr;

  modport master (
    output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    input  data_r, jump_en, jump_addr
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    output data_r, jump_en, jump_addr
  );
endinterface

// File: rtl/cp0_prio_enc.sv
// Lowest-index-wins priority encoder over the pending-and-unmasked interrupt lines.
module cp0_prio_enc
  import mips_define::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   req,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] index
);

  // Scan from the top so the lowest set line is the last assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IRQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cp0_vec.sv
// CP0 interrupt controller: STATUS/CAUSE/EPC/EHBR, edge-triggered IRQs, take/ERET redirect.
// Macro CP0_VECTOR_EN selects vectored targets (EHBR + index * VEC_STRIDE).
module cp0_vec
  import mips_define::*;
#(
  parameter int unsigned     NUM_IRQ    = 4,
  parameter logic [XLEN-1:0] VEC_STRIDE = 32'h20
) (
  input logic       clk,
  input logic       rst,
  cp0_vec_if.slave  bus
);

`ifdef CP0_VECTOR_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif
  localparam logic [XLEN-1:0] VEC_STEP = VECTORED ? VEC_STRIDE : '0;

  logic                 ie_q, ie_d, exl_q, exl_d;
  logic [NUM_IRQ-1:0]   im_q, im_d, ip_q, ip_d, ir_prev_q, ir_prev_d;
  logic [IRQ_IDX_W-1:0] id_q, id_d;
  logic [XLEN-1:0]      epc_q, epc_d, ehbr_q, ehbr_d;
  logic                 jump_en_q, jump_en_d;
  logic [XLEN-1:0]      jump_addr_q, jump_addr_d;

  logic [NUM_IRQ-1:0]   pending, rise, clr_mask;
  logic                 win_valid, eret, mtc0, take;
  logic [IRQ_IDX_W-1:0] win_idx;
  logic [XLEN-1:0]      rdata;

  assign pending = ip_q & im_q;

  cp0_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (pending),
    .valid (win_valid),
    .index (win_idx)
  );

  assign rise     = bus.ir_in & ~ir_prev_q;
  assign eret     = (bus.oper == OP_ERET);
  assign mtc0     = (bus.oper == OP_MTC0);
  // Decision uses pre-write state; ERET has priority over a take.
  assign take     = bus.ir_en & ie_q & ~exl_q & win_valid & ~eret;
  assign clr_mask = NUM_IRQ'(1) << win_idx;

  always_comb begin
    ie_d        = ie_q;
    exl_d       = exl_q;
    im_d        = im_q;
    ip_d        = ip_q;
    id_d        = id_q;
    epc_d       = epc_q;
    ehbr_d      = ehbr_q;
    ir_prev_d   = bus.ir_in;
    jump_en_d   = 1'b0;
    jump_addr_d = jump_addr_q;

    if (mtc0) begin
      case (bus.addr_w)
        CP0_STATUS: begin
          ie_d  = bus.data_w[0];
          exl_d = bus.data_w[1];
          im_d  = bus.data_w[8 +: NUM_IRQ];
        end
        CP0_CAUSE: ip_d   = ip_q & ~bus.data_w[8 +: NUM_IRQ];
        CP0_EPC:   epc_d  = bus.data_w;
        CP0_EHBR:  ehbr_d = bus.data_w;
        default: ;
      endcase
    end

    // Take/ERET updates are applied after the write so they override it.
    if (eret) begin
      exl_d       = 1'b0;
      jump_en_d   = 1'b1;
      jump_addr_d = epc_q;
    end else if (take) begin
      epc_d       = bus.ret_addr;
      exl_d       = 1'b1;
      ip_d        = ip_d & ~clr_mask;
      id_d        = win_idx;
      jump_en_d   = 1'b1;
      jump_addr_d = ehbr_q + XLEN'(win_idx) * VEC_STEP;
    end

    // A fresh edge beats any clear in the same cycle.
    ip_d = ip_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      im_q        <= '0;
      ip_q        <= '0;
      id_q        <= '0;
      epc_q       <= '0;
      ehbr_q      <= '0;
      ir_prev_q   <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      ie_q        <= ie_d;
      exl_q       <= exl_d;
      im_q        <= im_d;
      ip_q        <= ip_d;
      id_q        <= id_d;
      epc_q       <= epc_d;
      ehbr_q      <= ehbr_d;
      ir_prev_q   <= ir_prev_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr_r)
      CP0_STATUS: begin
        rdata[0]            = ie_q;
        rdata[1]            = exl_q;
        rdata[8 +: NUM_IRQ] = im_q;
      end
      CP0_CAUSE: begin
        rdata[8 +: NUM_IRQ] = ip_q;
        rdata[4:2]          = id_q;
      end
      CP0_EPC:  rdata = epc_q;
      CP0_EHBR: rdata = ehbr_q;
      default: ;
    endcase
  end

  assign bus.data_r    = rdata;
  assign bus.jump_en   = jump_en_q;
  assign bus.jump_addr = jump_addr_q;

endmodule
